// File: rtl/link_pkg.sv
// Shared link definitions: FSM state encoding and receive counter width.
// Used by the link slave and the link master family.
package link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DROP = 2'd2
  } link_state_e;

  localparam int RX_TOTAL_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; head visible the cycle after a push into an empty FIFO.
// No internal overflow/underflow guard: the caller pushes only when not full and pops only when not empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_fill;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign fill     = r_fill;

endmodule

// File: rtl/link_slave_fifo.sv
// Receive end of the 4-phase req/ack link: captures words into a FIFO drained by a valid/ready port.
// ack rises the cycle after capture and lasts ACK_CYCLES; a full FIFO withholds ack to stall the master.
module link_slave_fifo
  import link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int ACK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [DATA_W-1:0]         data_in,
  output logic                      ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [DATA_W-1:0]         last_word,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [RX_TOTAL_W-1:0]     rx_total,
  output logic                      proto_err
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int CW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

  link_state_e           r_state;
  logic                  r_ack;
  logic [CW-1:0]         r_cnt;
  logic [DATA_W-1:0]     r_last_word;
  logic [RX_TOTAL_W-1:0] r_rx_total;
  logic                  r_proto_err;

  logic [FW-1:0]         w_fill;
  logic                  w_full;
  logic                  w_capture;
  logic                  w_pop;

  // Full comes from registered occupancy, so a same-edge pop cannot admit a push.
  assign w_full    = (w_fill == FW'(DEPTH));
  assign w_capture = (r_state == IDLE) && req && !w_full;
  assign out_valid = (w_fill != '0);
  assign w_pop     = out_valid && out_ready;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_capture),
    .push_data (data_in),
    .pop       (w_pop),
    .pop_data  (out_data),
    .fill      (w_fill)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_cnt       <= '0;
      r_last_word <= '0;
      r_rx_total  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_state     <= ACK;
            r_ack       <= 1'b1;
            r_cnt       <= CW'(ACK_CYCLES - 1);
            r_last_word <= data_in;
            r_rx_total  <= r_rx_total + 1'b1;
          end
        end
        ACK: begin
          // Early req release is flagged but the handshake still runs to completion.
          if (!req) begin
            r_proto_err <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_state <= DROP;
            r_ack   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DROP: begin
          if (!req) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign fill      = w_fill;
  assign last_word = r_last_word;
  assign rx_total  = r_rx_total;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_link_slave_fifo.sv
// Directed bench for link_slave_fifo with a queue-based reference model checked every cycle.
module tb_link_slave_fifo;

  localparam int DW = 8;
  localparam int DP = 4;
  localparam int AC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [DW-1:0] data_in;
  logic          ack;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DW-1:0] last_word;
  logic [2:0]    fill;
  logic [15:0]   rx_total;
  logic          proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  link_slave_fifo #(.DATA_W(DW), .DEPTH(DP), .ACK_CYCLES(AC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .last_word (last_word),
    .fill      (fill),
    .rx_total  (rx_total),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a word queue plus remaining-ack and waiting-for-release bookkeeping.
  logic [DW-1:0] m_q[$];
  int            m_ack_left = 0;
  bit            m_in_drop  = 0;
  logic [DW-1:0] m_last     = '0;
  logic [15:0]   m_total    = '0;
  bit            m_err      = 0;

  task automatic model_step();
    int  occ;
    bit  do_pop;
    bit  do_push;
    if (!rst) begin
      m_q.delete();
      m_ack_left = 0;
      m_in_drop  = 0;
      m_last     = '0;
      m_total    = '0;
      m_err      = 0;
      return;
    end
    occ     = m_q.size();
    do_pop  = (occ > 0) && out_ready;
    do_push = 0;
    if (m_ack_left > 0) begin
      if (!req) m_err = 1;
      m_ack_left--;
      if (m_ack_left == 0) m_in_drop = 1;
    end else if (m_in_drop) begin
      if (!req) m_in_drop = 0;
    end else if (req && occ < DP) begin
      do_push    = 1;
      m_ack_left = AC;
      m_last     = data_in;
      m_total    = m_total + 16'd1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(data_in);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (rst) begin
        check("cyc_ack", ack, (m_ack_left > 0));
        check("cyc_out_valid", out_valid, (m_q.size() > 0));
        check("cyc_fill", fill, m_q.size());
        check("cyc_last_word", last_word, m_last);
        check("cyc_rx_total", rx_total, m_total);
        check("cyc_proto_err", proto_err, m_err);
        if (m_q.size() > 0) check("cyc_out_data", out_data, m_q[0]);
      end
    end
  end

  task automatic wait_ack(input logic lvl);
    int n = 0;
    while (ack !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ack !== lvl) check("ack_wait_timeout", ack, lvl);
  endtask

  task automatic xfer(input logic [DW-1:0] d, output int acks);
    req = 1'b1;
    data_in = d;
    acks = 0;
    wait_ack(1'b1);
    while (ack && acks < 100) begin
      acks++;
      @(negedge clk);
    end
    req = 1'b0;
    data_in = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int cnt;
    rst = 1'b0; req = 1'b0; data_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_last", last_word, 0);
    check("rst_total", rx_total, 0);
    check("rst_perr", proto_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single transfer
    xfer(8'hA5, acks);
    check("single_ack_len", acks, 2);
    check("single_last", last_word, 8'hA5);
    check("single_out", out_data, 8'hA5);
    check("single_fill", fill, 1);
    check("single_total", rx_total, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_popped", fill, 0);

    // Backpressure: four fit, fifth stalls until one pop
    for (int i = 1; i <= 4; i++) begin
      xfer(DW'(i), acks);
      check("bp_ack_len", acks, 2);
    end
    check("bp_fill_full", fill, 4);
    req = 1'b1; data_in = 8'h05;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ack", ack, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_pop_no_ack", ack, 0);
    check("bp_pop_fill", fill, 3);
    check("bp_head", out_data, 8'h02);
    @(negedge clk);
    check("bp_release_ack", ack, 1);
    check("bp_release_fill", fill, 4);
    check("bp_release_last", last_word, 8'h05);
    wait_ack(1'b0);
    req = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("bp_drain", out_data, i);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("bp_drain_empty", out_valid, 0);

    // Simultaneous push and pop at fill 2
    xfer(8'h10, acks);
    xfer(8'h11, acks);
    check("pp_fill_pre", fill, 2);
    req = 1'b1; data_in = 8'h12; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pp_fill", fill, 2);
    check("pp_ack", ack, 1);
    check("pp_head", out_data, 8'h11);
    wait_ack(1'b0);
    req = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    check("pp_out1", out_data, 8'h11);
    @(negedge clk);
    check("pp_out2", out_data, 8'h12);
    @(negedge clk);
    out_ready = 1'b0;
    check("pp_empty", fill, 0);

    // Protocol error: req released one cycle into ack
    out_ready = 1'b1;
    req = 1'b1; data_in = 8'h20;
    wait_ack(1'b1);
    cnt = 1;
    @(negedge clk);
    req = 1'b0;
    while (ack && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    check("perr_ack_len", cnt, 2);
    check("perr_flag", proto_err, 1);
    xfer(8'h21, acks);
    check("perr_next_ack", acks, 2);
    check("perr_sticky", proto_err, 1);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a handshake with three words buffered
    xfer(8'h30, acks);
    xfer(8'h31, acks);
    req = 1'b1; data_in = 8'h32;
    wait_ack(1'b1);
    check("mr_fill_pre", fill, 3);
    #1 rst = 1'b0;
    #1;
    check("mr_ack", ack, 0);
    check("mr_fill", fill, 0);
    check("mr_valid", out_valid, 0);
    check("mr_total", rx_total, 0);
    check("mr_perr", proto_err, 0);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(8'h3C, acks);
    check("mr_new_ack", acks, 2);
    check("mr_new_out", out_data, 8'h3C);
    check("mr_new_fill", fill, 1);
    check("mr_new_total", rx_total, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Pointer wrap: two full fill/drain rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) xfer(DW'(8'h40 + 4 * r + i), acks);
      check("wrap_full", fill, 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        check("wrap_data", out_data, 8'h40 + 4 * r + i);
        @(negedge clk);
      end
      out_ready = 1'b0;
    end
    check("wrap_total", rx_total, 9);

    // Counter wrap from 0xFFFF
    force dut.r_rx_total = 16'hFFFF;
    m_total = 16'hFFFF;
    #1 release dut.r_rx_total;
    @(negedge clk);
    check("cnt_preload", rx_total, 16'hFFFF);
    xfer(8'h55, acks);
    check("cnt_wrap", rx_total, 0);
    check("cnt_wrap_out", out_data, 8'h55);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
